// File: rtl/mips_dbg_pkg.sv
// Shared definitions for the pipe_MIPS32 debug/load port: host opcodes,
// FSM states and the instruction opcodes used to assemble test programs.
package mips_dbg_pkg;

   typedef enum logic [1:0] {
      OP_MEM_WR = 2'b00,
      OP_REG_RD = 2'b01,
      OP_RUN    = 2'b10,
      OP_NOP    = 2'b11
   } dbg_op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MEMWR,
      ST_RDADDR,
      ST_RDWAIT,
      ST_RUNSTART,
      ST_RUNWAIT,
      ST_RESP
   } dbg_state_e;

   localparam logic [5:0] HLT  = 6'h3f;
   localparam logic [5:0] ADDI = 6'h0a;

   // Every command except NOP touches the core and is only legal while it is halted.
   function automatic logic op_needs_halt(input dbg_op_e op);
      return op != OP_NOP;
   endfunction

endpackage

// File: rtl/mips_dbg_port_if.sv
// Host link of the debug port: command request and response handshake.
interface mips_dbg_port_if
   import mips_dbg_pkg::*;
#(
   parameter int AW = 10,
   parameter int DW = 32
);
   logic          cmd_valid;
   logic          cmd_ready;
   dbg_op_e       cmd_op;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_data;
   logic          rsp_err;

   modport master (
      output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/mips_dbg_run_timer.sv
// Run-length counter: counts enabled cycles, saturates at MAX and flags the
// timeout on the same edge the count reaches MAX.
module mips_dbg_run_timer #(
   parameter int MAX = 1024,
   parameter int CW  = $clog2(MAX + 1)
) (
   input  logic          clk1,
   input  logic          rst_n,
   input  logic          i_clr,
   input  logic          i_en,
   output logic [CW-1:0] o_cnt,
   output logic          o_tmo
);
   localparam logic [CW-1:0] L_MAX = CW'(MAX);
   localparam logic [CW-1:0] L_PRE = CW'(MAX - 1);

   logic [CW-1:0] r_cnt;

   // Count enabled cycles, holding at MAX instead of wrapping.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != L_MAX)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;
   // Look ahead one increment so the FSM leaves exactly when the count hits MAX.
   assign o_tmo = (r_cnt == L_MAX) || (i_en && (r_cnt == L_PRE));

endmodule

// File: rtl/mips_dbg_port.sv
// Host-side debug/load port for pipe_MIPS32: loads memory words, starts the
// core from PC=0, times the run and reads registers back once it has halted.
module mips_dbg_port
   import mips_dbg_pkg::*;
#(
   parameter int AW          = 10,
   parameter int DW          = 32,
   parameter int RUN_TIMEOUT = 1024
) (
   input  logic           clk1,
   input  logic           rst_n,
   mips_dbg_port_if.slave host,
   output logic           mem_we,
   output logic [AW-1:0]  mem_addr,
   output logic [DW-1:0]  mem_wdata,
   output logic [4:0]     reg_raddr,
   input  logic [DW-1:0]  reg_rdata,
   input  logic           cpu_halted,
   output logic           cpu_start
);
   localparam int CW = $clog2(RUN_TIMEOUT + 1);

   dbg_state_e    r_state;
   logic          r_cmd_ready;
   logic          r_rsp_valid;
   logic          r_rsp_err;
   logic [DW-1:0] r_rsp_data;
   logic          r_mem_we;
   logic [AW-1:0] r_mem_addr;
   logic [DW-1:0] r_mem_wdata;
   logic [4:0]    r_reg_raddr;
   logic          r_cpu_start;
   logic          r_first;

   logic          w_tmr_clr;
   logic          w_tmr_en;
   logic          w_tmo;
   logic [CW-1:0] w_cnt;

   assign w_tmr_clr = (r_state == ST_RUNSTART);
   assign w_tmr_en  = (r_state == ST_RUNWAIT) && !cpu_halted;

   mips_dbg_run_timer #(
      .MAX (RUN_TIMEOUT),
      .CW  (CW)
   ) u_timer (
      .clk1  (clk1),
      .rst_n (rst_n),
      .i_clr (w_tmr_clr),
      .i_en  (w_tmr_en),
      .o_cnt (w_cnt),
      .o_tmo (w_tmo)
   );

   // Command FSM; every output is a register so the core hooks see clean pulses.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cmd_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_data  <= '0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_reg_raddr <= '0;
         r_cpu_start <= 1'b0;
         r_first     <= 1'b0;
      end else begin
         r_mem_we    <= 1'b0;
         r_cpu_start <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (host.cmd_valid && r_cmd_ready) begin
                  r_cmd_ready <= 1'b0;
                  if (op_needs_halt(host.cmd_op) && !cpu_halted) begin
                     // Core is running: refuse without touching memory or control.
                     r_state     <= ST_RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b1;
                     r_rsp_data  <= '0;
                  end else begin
                     case (host.cmd_op)
                        OP_MEM_WR: begin
                           r_mem_we    <= 1'b1;
                           r_mem_addr  <= host.cmd_addr;
                           r_mem_wdata <= host.cmd_wdata;
                           r_state     <= ST_MEMWR;
                        end
                        OP_REG_RD: begin
                           r_reg_raddr <= host.cmd_addr[4:0];
                           r_state     <= ST_RDADDR;
                        end
                        OP_RUN: begin
                           r_cpu_start <= 1'b1;
                           r_state     <= ST_RUNSTART;
                        end
                        default: begin
                           r_state     <= ST_RESP;
                           r_rsp_valid <= 1'b1;
                           r_rsp_err   <= 1'b0;
                           r_rsp_data  <= '0;
                        end
                     endcase
                  end
               end
            end
            ST_MEMWR: begin
               r_state     <= ST_RESP;
               r_rsp_valid <= 1'b1;
               r_rsp_err   <= 1'b0;
               r_rsp_data  <= '0;
            end
            ST_RDADDR: begin
               r_state <= ST_RDWAIT;
            end
            ST_RDWAIT: begin
               r_state     <= ST_RESP;
               r_rsp_valid <= 1'b1;
               r_rsp_err   <= 1'b0;
               r_rsp_data  <= reg_rdata;
            end
            ST_RUNSTART: begin
               r_first <= 1'b1;
               r_state <= ST_RUNWAIT;
            end
            ST_RUNWAIT: begin
               r_first <= 1'b0;
               // HALTED is still stale in the first wait cycle, so it cannot end the run yet.
               if (!r_first && cpu_halted) begin
                  r_state     <= ST_RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b0;
                  r_rsp_data  <= DW'(w_cnt);
               end else if (w_tmo) begin
                  r_state     <= ST_RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b1;
                  r_rsp_data  <= DW'(RUN_TIMEOUT);
               end
            end
            ST_RESP: begin
               if (host.rsp_ready) begin
                  r_state     <= ST_IDLE;
                  r_cmd_ready <= 1'b1;
                  r_rsp_valid <= 1'b0;
                  r_rsp_err   <= 1'b0;
                  r_rsp_data  <= '0;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_cmd_ready <= 1'b1;
               r_rsp_valid <= 1'b0;
               r_rsp_err   <= 1'b0;
               r_rsp_data  <= '0;
            end
         endcase
      end
   end

   assign host.cmd_ready = r_cmd_ready;
   assign host.rsp_valid = r_rsp_valid;
   assign host.rsp_err   = r_rsp_err;
   assign host.rsp_data  = r_rsp_data;
   assign mem_we         = r_mem_we;
   assign mem_addr       = r_mem_addr;
   assign mem_wdata      = r_mem_wdata;
   assign reg_raddr      = r_reg_raddr;
   assign cpu_start      = r_cpu_start;

endmodule

// File: tb/tb_mips_dbg_port.sv
// Bench for mips_dbg_port: a behavioural core (register file, program
// interpreter, halt timing) drives the hooks; expectations come from the
// command rules and the loaded program.
module tb_mips_dbg_port;
   import mips_dbg_pkg::*;

   localparam int AW = 10;
   localparam int DW = 32;
   localparam int RUN_TIMEOUT = 1024;

   typedef struct {
      int            lat;
      int            n_we;
      int            n_start;
      int            k_start;
      bit            tmo;
      logic [AW-1:0] we_addr;
      logic [DW-1:0] we_data;
      logic          err;
      logic [DW-1:0] data;
   } rsp_t;

   logic          clk1 = 1'b0;
   logic          rst_n;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [4:0]    reg_raddr;
   logic [DW-1:0] reg_rdata;
   logic          cpu_halted;
   logic          cpu_start;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] core_regs [0:31];
   logic [31:0] imem [0:1023];
   logic [31:0] prog [0:8] = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800,
                               32'h0ce77800, 32'h00222000, 32'h0ce77800, 32'h00832800,
                               32'hfc000000};
   logic [31:0] exp_rb [1:5] = '{32'd10, 32'd20, 32'd25, 32'd30, 32'd55};

   mips_dbg_port_if #(.AW(AW), .DW(DW)) u_if ();

   mips_dbg_port #(.AW(AW), .DW(DW), .RUN_TIMEOUT(RUN_TIMEOUT)) u_dut (
      .clk1       (clk1),
      .rst_n      (rst_n),
      .host       (u_if.slave),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .reg_raddr  (reg_raddr),
      .reg_rdata  (reg_rdata),
      .cpu_halted (cpu_halted),
      .cpu_start  (cpu_start)
   );

   always #5 clk1 = ~clk1;

   // Core register file: synchronous read, data one cycle after the index.
   always @(posedge clk1) reg_rdata <= core_regs[reg_raddr];

   // Core behaviour on start: execute the loaded program from PC=0 until HLT.
   task automatic core_exec();
      logic [31:0] w;
      bit done = 0;
      for (int pc = 0; pc < 64 && !done; pc++) begin
         w = imem[pc];
         case (w[31:26])
            HLT:   done = 1;
            ADDI:  if (w[20:16] != 5'd0) core_regs[w[20:16]] = core_regs[w[25:21]] + {{16{w[15]}}, w[15:0]};
            6'h00: if (w[15:11] != 5'd0) core_regs[w[15:11]] = core_regs[w[25:21]] + core_regs[w[20:16]];
            6'h03: if (w[15:11] != 5'd0) core_regs[w[15:11]] = core_regs[w[25:21]] | core_regs[w[20:16]];
            default: ;
         endcase
      end
   endtask

   task automatic clear_rsp(output rsp_t r);
      r.lat = 0; r.n_we = 0; r.n_start = 0; r.k_start = -1; r.tmo = 0;
      r.we_addr = '0; r.we_data = '0; r.err = 1'b0; r.data = '0;
   endtask

   // Issue one command and wait (bounded) for its response; records side effects.
   task automatic issue(input dbg_op_e op, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        output rsp_t r);
      clear_rsp(r);
      u_if.cmd_op = op; u_if.cmd_addr = addr; u_if.cmd_wdata = wdata; u_if.cmd_valid = 1'b1;
      @(posedge clk1); #1;
      u_if.cmd_valid = 1'b0;
      r.lat = 1;
      while (1) begin
         if (mem_we === 1'b1) begin r.n_we++; r.we_addr = mem_addr; r.we_data = mem_wdata; end
         if (cpu_start === 1'b1) r.n_start++;
         if (u_if.rsp_valid === 1'b1) break;
         if (r.lat >= 20) begin r.tmo = 1; break; end
         @(posedge clk1); #1;
         r.lat++;
      end
      r.err = u_if.rsp_err; r.data = u_if.rsp_data;
   endtask

   // RUN with a core that leaves HALTED d cycles late, runs n cycles, or never halts.
   task automatic do_run(input int d, input int n, input bit stuck, output rsp_t r);
      clear_rsp(r);
      u_if.cmd_op = OP_RUN; u_if.cmd_valid = 1'b1;
      @(posedge clk1); #1;
      u_if.cmd_valid = 1'b0;
      while (u_if.rsp_valid !== 1'b1 && r.lat < 1500) begin
         if (cpu_start === 1'b1) begin
            r.n_start++;
            if (r.k_start < 0) begin r.k_start = r.lat; core_exec(); end
         end
         if (r.k_start >= 0 && r.lat == r.k_start + 1 + d) cpu_halted = 1'b0;
         if (r.k_start >= 0 && !stuck && r.lat == r.k_start + 1 + d + n) cpu_halted = 1'b1;
         @(posedge clk1); #1;
         r.lat++;
      end
      r.tmo = (u_if.rsp_valid !== 1'b1);
      r.err = u_if.rsp_err; r.data = u_if.rsp_data;
   endtask

   task automatic ack(input string name);
      u_if.rsp_ready = 1'b1;
      @(posedge clk1); #1;
      u_if.rsp_ready = 1'b0;
      n_cmp++;
      if (u_if.cmd_ready !== 1'b1 || u_if.rsp_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL %s_ack: cmd_ready=%b rsp_valid=%b, want cmd_ready=1 rsp_valid=0",
                  name, u_if.cmd_ready, u_if.rsp_valid);
      end
   endtask

   task automatic test_reset();
      logic [DW+2*AW+DW+DW+9:0] got;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk1);
      #1;
      got = {u_if.cmd_ready, u_if.rsp_valid, u_if.rsp_err, u_if.rsp_data, mem_we, mem_addr,
             mem_wdata, reg_raddr, cpu_start, {AW{1'b0}}};
      n_cmp++;
      if (got !== {1'b1, 1'b0, 1'b0, {DW{1'b0}}, 1'b0, {AW{1'b0}}, {DW{1'b0}}, 5'd0, 1'b0, {AW{1'b0}}}) begin
         n_bad++;
         $display("FAIL reset_values: ready=%b rvalid=%b err=%b rdata=%h we=%b maddr=%h mwdata=%h raddr=%h start=%b, want ready=1 rest 0",
                  u_if.cmd_ready, u_if.rsp_valid, u_if.rsp_err, u_if.rsp_data, mem_we, mem_addr,
                  mem_wdata, reg_raddr, cpu_start);
      end
      rst_n = 1'b1;
      @(posedge clk1); #1;
   endtask

   task automatic test_load_run();
      rsp_t r;
      int n;
      for (int i = 0; i < 9; i++) begin
         issue(OP_MEM_WR, AW'(i), prog[i], r);
         n_cmp++;
         if (r.tmo || r.lat != 2 || r.n_we != 1 || r.we_addr !== AW'(i) || r.we_data !== prog[i] ||
             r.err !== 1'b0 || r.data !== '0) begin
            n_bad++;
            $display("FAIL load_memwr[%0d]: lat=%0d we=%0d addr=%h data=%h err=%b rdata=%h, want lat=2 we=1 addr=%h data=%h err=0 rdata=0",
                     i, r.lat, r.n_we, r.we_addr, r.we_data, r.err, r.data, AW'(i), prog[i]);
         end
         imem[i] = prog[i];
         ack("load_memwr");
      end
      for (int d = 0; d < 2; d++) begin
         n = $urandom_range(1, 40);
         do_run(d, n, 1'b0, r);
         n_cmp++;
         if (r.tmo || r.n_start != 1 || r.k_start != 0 || r.lat != 2 + d + n || r.err !== 1'b0 ||
             r.data !== DW'(n) || r.data == '0) begin
            n_bad++;
            $display("FAIL run_d%0d: starts=%0d kstart=%0d lat=%0d err=%b data=%0d, want starts=1 kstart=0 lat=%0d err=0 data=%0d",
                     d, r.n_start, r.k_start, r.lat, r.err, r.data, 2 + d + n, n);
         end
         ack("run");
      end
   endtask

   task automatic test_readback();
      rsp_t r;
      logic [AW-1:0] a;
      int idx;
      for (int i = 1; i <= 5; i++) begin
         a = AW'($urandom);
         a[4:0] = 5'(i);
         issue(OP_REG_RD, a, DW'($urandom), r);
         n_cmp++;
         if (r.tmo || r.lat != 3 || r.err !== 1'b0 || r.data !== exp_rb[i] || r.data !== core_regs[i]) begin
            n_bad++;
            $display("FAIL readback_r%0d: lat=%0d err=%b data=%0d, want lat=3 err=0 data=%0d",
                     i, r.lat, r.err, r.data, exp_rb[i]);
         end
         ack("readback");
      end
      for (int j = 0; j < 6; j++) begin
         idx = $urandom_range(0, 31);
         a = AW'($urandom);
         a[4:0] = 5'(idx);
         issue(OP_REG_RD, a, '0, r);
         n_cmp++;
         if (r.tmo || r.lat != 3 || r.err !== 1'b0 || r.data !== core_regs[idx]) begin
            n_bad++;
            $display("FAIL readback_rand_r%0d: lat=%0d err=%b data=%h, want lat=3 err=0 data=%h",
                     idx, r.lat, r.err, r.data, core_regs[idx]);
         end
         ack("readback_rand");
      end
   endtask

   task automatic test_backpressure();
      rsp_t r;
      issue(OP_REG_RD, 10'h3e2, '0, r);
      n_cmp++;
      if (r.tmo || r.lat != 3 || r.data !== 32'd20) begin
         n_bad++;
         $display("FAIL bp_first: lat=%0d data=%0d, want lat=3 data=20", r.lat, r.data);
      end
      for (int i = 0; i < 5; i++) begin
         if (i == 0) begin
            u_if.cmd_op = OP_MEM_WR; u_if.cmd_addr = 10'd5; u_if.cmd_wdata = $urandom; u_if.cmd_valid = 1'b1;
         end
         if (i == 4) u_if.cmd_valid = 1'b0;
         n_cmp++;
         if (u_if.rsp_valid !== 1'b1 || u_if.rsp_data !== 32'd20 || u_if.rsp_err !== 1'b0 ||
             u_if.cmd_ready !== 1'b0 || mem_we !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_hold[%0d]: rvalid=%b data=%0d err=%b ready=%b we=%b, want rvalid=1 data=20 err=0 ready=0 we=0",
                     i, u_if.rsp_valid, u_if.rsp_data, u_if.rsp_err, u_if.cmd_ready, mem_we);
         end
         @(posedge clk1); #1;
      end
      ack("bp");
      @(posedge clk1); #1;
      n_cmp++;
      if (mem_we !== 1'b0 || u_if.rsp_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL bp_busy_cmd_ignored: we=%b rvalid=%b, want we=0 rvalid=0", mem_we, u_if.rsp_valid);
      end
   endtask

   task automatic test_reject();
      rsp_t r;
      cpu_halted = 1'b0;
      issue(OP_MEM_WR, 10'd3, DW'($urandom), r);
      n_cmp++;
      if (r.tmo || r.lat != 1 || r.n_we != 0 || r.err !== 1'b1 || r.data !== '0) begin
         n_bad++;
         $display("FAIL reject_memwr: lat=%0d we=%0d err=%b data=%h, want lat=1 we=0 err=1 data=0",
                  r.lat, r.n_we, r.err, r.data);
      end
      ack("reject_memwr");
      issue(OP_REG_RD, 10'd2, '0, r);
      n_cmp++;
      if (r.tmo || r.lat != 1 || r.err !== 1'b1 || r.data !== '0) begin
         n_bad++;
         $display("FAIL reject_regrd: lat=%0d err=%b data=%h, want lat=1 err=1 data=0", r.lat, r.err, r.data);
      end
      ack("reject_regrd");
      issue(OP_RUN, '0, '0, r);
      n_cmp++;
      if (r.tmo || r.lat != 1 || r.n_start != 0 || r.err !== 1'b1 || r.data !== '0) begin
         n_bad++;
         $display("FAIL reject_run: lat=%0d starts=%0d err=%b data=%h, want lat=1 starts=0 err=1 data=0",
                  r.lat, r.n_start, r.err, r.data);
      end
      ack("reject_run");
      issue(OP_NOP, '0, '0, r);
      n_cmp++;
      if (r.tmo || r.lat != 1 || r.err !== 1'b0 || r.data !== '0) begin
         n_bad++;
         $display("FAIL nop_running: lat=%0d err=%b data=%h, want lat=1 err=0 data=0", r.lat, r.err, r.data);
      end
      ack("nop_running");
      cpu_halted = 1'b1;
   endtask

   task automatic test_timeout();
      rsp_t r;
      int d;
      d = $urandom_range(0, 1);
      do_run(d, 0, 1'b1, r);
      n_cmp++;
      if (r.tmo || r.n_start != 1 || r.lat != r.k_start + 1 + d + RUN_TIMEOUT || r.err !== 1'b1 ||
          r.data !== DW'(RUN_TIMEOUT)) begin
         n_bad++;
         $display("FAIL timeout: starts=%0d kstart=%0d lat=%0d err=%b data=%0d, want starts=1 lat=%0d err=1 data=%0d",
                  r.n_start, r.k_start, r.lat, r.err, r.data, r.k_start + 1 + d + RUN_TIMEOUT, RUN_TIMEOUT);
      end
      cpu_halted = 1'b1;
      ack("timeout");
   endtask

   task automatic test_back_to_back();
      rsp_t r;
      int sel;
      int idx;
      logic [AW-1:0] a;
      logic [DW-1:0] wd;
      for (int i = 0; i < 16; i++) begin
         sel = $urandom_range(0, 2);
         wd = $urandom;
         if (sel == 0) begin
            a = AW'($urandom_range(16, 1023));
            issue(OP_MEM_WR, a, wd, r);
            n_cmp++;
            if (r.tmo || r.lat != 2 || r.n_we != 1 || r.we_addr !== a || r.we_data !== wd || r.err !== 1'b0 || r.data !== '0) begin
               n_bad++;
               $display("FAIL b2b_memwr[%0d]: lat=%0d we=%0d addr=%h data=%h err=%b, want lat=2 we=1 addr=%h data=%h err=0",
                        i, r.lat, r.n_we, r.we_addr, r.we_data, r.err, a, wd);
            end
            imem[a] = wd;
         end else if (sel == 1) begin
            idx = $urandom_range(0, 31);
            a = AW'($urandom);
            a[4:0] = 5'(idx);
            issue(OP_REG_RD, a, wd, r);
            n_cmp++;
            if (r.tmo || r.lat != 3 || r.n_we != 0 || r.err !== 1'b0 || r.data !== core_regs[idx]) begin
               n_bad++;
               $display("FAIL b2b_regrd[%0d]: lat=%0d we=%0d err=%b data=%h, want lat=3 we=0 err=0 data=%h",
                        i, r.lat, r.n_we, r.err, r.data, core_regs[idx]);
            end
         end else begin
            issue(OP_NOP, AW'($urandom), wd, r);
            n_cmp++;
            if (r.tmo || r.lat != 1 || r.n_we != 0 || r.n_start != 0 || r.err !== 1'b0 || r.data !== '0) begin
               n_bad++;
               $display("FAIL b2b_nop[%0d]: lat=%0d we=%0d start=%0d err=%b data=%h, want lat=1 none err=0 data=0",
                        i, r.lat, r.n_we, r.n_start, r.err, r.data);
            end
         end
         repeat ($urandom_range(0, 2)) begin @(posedge clk1); #1; end
         ack("b2b");
      end
   endtask

   task automatic test_reset_midrun();
      rsp_t r;
      u_if.cmd_op = OP_RUN; u_if.cmd_valid = 1'b1;
      @(posedge clk1); #1;
      u_if.cmd_valid = 1'b0;
      n_cmp++;
      if (cpu_start !== 1'b1) begin
         n_bad++;
         $display("FAIL midrun_start: cpu_start=%b, want 1", cpu_start);
      end
      @(posedge clk1); #1;
      cpu_halted = 1'b0;
      repeat (8) begin @(posedge clk1); #1; end
      n_cmp++;
      if (u_if.rsp_valid !== 1'b0 || u_if.cmd_ready !== 1'b0 || cpu_start !== 1'b0) begin
         n_bad++;
         $display("FAIL midrun_busy: rvalid=%b ready=%b start=%b, want 0 0 0", u_if.rsp_valid, u_if.cmd_ready, cpu_start);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (u_if.rsp_valid !== 1'b0 || u_if.cmd_ready !== 1'b1 || cpu_start !== 1'b0) begin
         n_bad++;
         $display("FAIL midrun_async_reset: rvalid=%b ready=%b start=%b, want 0 1 0", u_if.rsp_valid, u_if.cmd_ready, cpu_start);
      end
      repeat (2) @(posedge clk1);
      #1 rst_n = 1'b1;
      cpu_halted = 1'b1;
      repeat (3) begin @(posedge clk1); #1; end
      n_cmp++;
      if (u_if.rsp_valid !== 1'b0 || u_if.cmd_ready !== 1'b1 || cpu_start !== 1'b0) begin
         n_bad++;
         $display("FAIL midrun_release: rvalid=%b ready=%b start=%b, want 0 1 0", u_if.rsp_valid, u_if.cmd_ready, cpu_start);
      end
      // A memory write caught by reset is dropped.
      u_if.cmd_op = OP_MEM_WR; u_if.cmd_addr = 10'h155; u_if.cmd_wdata = 32'hdeadbeef; u_if.cmd_valid = 1'b1;
      @(posedge clk1); #1;
      u_if.cmd_valid = 1'b0;
      n_cmp++;
      if (mem_we !== 1'b1) begin
         n_bad++;
         $display("FAIL inflight_we: mem_we=%b, want 1", mem_we);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
         n_bad++;
         $display("FAIL inflight_dropped: we=%b addr=%h data=%h, want 0 0 0", mem_we, mem_addr, mem_wdata);
      end
      @(posedge clk1);
      #1 rst_n = 1'b1;
      issue(OP_NOP, '0, '0, r);
      n_cmp++;
      if (r.tmo || r.lat != 1 || r.err !== 1'b0) begin
         n_bad++;
         $display("FAIL post_reset_nop: lat=%0d err=%b, want lat=1 err=0", r.lat, r.err);
      end
      ack("post_reset_nop");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      u_if.cmd_valid = 1'b0; u_if.cmd_op = OP_NOP; u_if.cmd_addr = '0; u_if.cmd_wdata = '0;
      u_if.rsp_ready = 1'b0;
      cpu_halted = 1'b1;
      for (int i = 0; i < 1024; i++) imem[i] = '0;
      core_regs[0] = '0;
      for (int i = 1; i < 32; i++) core_regs[i] = $urandom;
      test_reset();
      test_load_run();
      test_readback();
      test_backpressure();
      test_reject();
      test_timeout();
      test_back_to_back();
      test_reset_midrun();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mips_dbg_port.md
Name: mips_dbg_port

Overview:
- Host-side debug/load port for pipe_MIPS32.
- Writes program words into instruction/data memory and releases the core from halt.
- After HLT, reads the register file back through a registered request/response handshake.
- Synthesizable replacement for bench-side hierarchical preload and readback; sits between a host link and the core's Mem/Reg/control hooks.

Parameters:
- AW, 10, memory word-address width
- DW, 32, data width
- RUN_TIMEOUT, 1024, max clk1 cycles to wait for the core to halt after RUN

Ports:
- clk1  in  1  single clock; core stage clock domain
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  port can accept a command
- cmd_op  in  2  00=MEM_WR, 01=REG_RD, 10=RUN, 11=NOP
- cmd_addr  in  AW  memory word address (MEM_WR) or register index [4:0] (REG_RD)
- cmd_wdata  in  DW  write data for MEM_WR
- rsp_valid  out  1  response valid
- rsp_ready  in  1  host accepts response
- rsp_data  out  DW  register value (REG_RD), cycle count (RUN), 0 otherwise
- rsp_err  out  1  command rejected or timed out
- mem_we  out  1  memory write strobe, one cycle
- mem_addr  out  AW  memory write address
- mem_wdata  out  DW  memory write data
- reg_raddr  out  5  register-file read index
- reg_rdata  in  DW  register-file data, valid one cycle after reg_raddr
- cpu_halted  in  1  core HALTED flag
- cpu_start  out  1  one-cycle pulse: core clears HALTED and TAKEN_BRANCH and sets PC=0

Behaviour:
- Reset values (async, all outputs):
  - cmd_ready=1
  - rsp_valid=0, rsp_err=0, rsp_data=0
  - mem_we=0, mem_addr=0, mem_wdata=0
  - reg_raddr=0, cpu_start=0
  - FSM in IDLE; cycle counter=0
- FSM states: IDLE, MEMWR, RDADDR, RDWAIT, RUNSTART, RUNWAIT, RESP.
- Handshake rules:
  - A command is accepted on a clk1 edge with cmd_valid & cmd_ready.
  - cmd_ready=1 only in IDLE.
  - Each accepted command produces exactly one response.
  - A response holds rsp_valid/rsp_data/rsp_err stable until rsp_valid & rsp_ready, then the FSM returns to IDLE.
- Halt check:
  - If cpu_halted=0 at acceptance, MEM_WR, REG_RD and RUN go directly to RESP with rsp_err=1 and rsp_data=0.
  - No memory write and no cpu_start occur in that case.
- NOP: goes to RESP with err=0, data=0.
- MEM_WR:
  - Accept -> MEMWR: mem_we=1 for exactly one cycle with the latched addr/data -> RESP (data=0).
  - Latency from accept to rsp_valid is 2 cycles.
- REG_RD:
  - Accept -> RDADDR: drive reg_raddr=cmd_addr[4:0].
  - -> RDWAIT: capture reg_rdata.
  - -> RESP.
  - rsp_valid rises 3 cycles after accept.
  - cmd_addr bits above [4:0] are ignored.
- RUN:
  - Accept -> RUNSTART: cpu_start=1 for one cycle; counter cleared.
  - -> RUNWAIT: counter increments each cycle while cpu_halted=0.
  - cpu_halted is ignored in the first RUNWAIT cycle because the core deasserts it one cycle after cpu_start.
  - cpu_halted=1 (after the first cycle) -> RESP with rsp_data=counter, err=0.
  - Counter reaching RUN_TIMEOUT -> RESP with err=1, data=RUN_TIMEOUT. The core is left running.
  - Counter saturates and never wraps.
- Reset mid-operation:
  - Abort immediately; all outputs go to reset values.
  - A pending response is lost.
  - A mem_we in flight is dropped.
- cmd_valid while busy is ignored (cmd_ready=0). The host must hold it.

Decomposition:
- Package mips_dbg_pkg:
  - op encodings OP_MEM_WR/OP_REG_RD/OP_RUN/OP_NOP
  - FSM state enum
  - opcode constants HLT=6'h3f, ADDI=6'h0a (shared with the bench for program assembly)
- Sub-module mips_dbg_run_timer: cycle counter with clear, enable, saturation and timeout flag. Everything else stays in one module.

Test Plan:
- Reset: assert rst_n=0 mid-RUNWAIT -> cpu_start=0, rsp_valid=0, cmd_ready=1 on release.
- Load and run:
  - With cpu_halted=1, MEM_WR addr 0..8 with 2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 00832800, fc000000.
  - Expect -> nine mem_we pulses with matching addr/data, all rsp_err=0.
  - RUN -> one cpu_start pulse; response when the core halts, err=0, nonzero cycle count.
- Readback after the above program:
  - REG_RD 1..5 -> rsp_data 10, 20, 25, 30, 55.
  - Each response arrives 3 cycles after accept.
- Reject while running: hold cpu_halted=0 and issue MEM_WR addr 3 -> rsp_err=1, mem_we never asserted.
- Timeout: RUN with cpu_halted stuck 0 after start -> rsp_err=1, rsp_data=1024 (RUN_TIMEOUT) after 1024 RUNWAIT cycles.
- Backpressure: rsp_ready=0 for 5 cycles on a REG_RD 2 response -> rsp_valid/rsp_data=20 held stable, cmd_ready=0 throughout, IDLE one cycle after rsp_ready=1.
